// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve unit: funct3 selects, branch kinds,
// FSM state codes and the captured comparator flag bundle.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] KIND_COND = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;

    typedef logic [1:0] br_state_t;

    localparam br_state_t ST_IDLE     = 2'd0;
    localparam br_state_t ST_EVAL     = 2'd1;
    localparam br_state_t ST_REDIRECT = 2'd2;

    typedef struct packed {
        logic beq;
        logic bne;
        logic blt;
        logic bge;
        logic bltu;
        logic bgeu;
    } br_flags_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch offer from execute plus the redirect handshake towards fetch.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            br_valid_i;
    logic            br_ready_o;
    logic [1:0]      br_kind_i;
    logic [2:0]      br_funct3_i;
    logic [XLEN-1:0] br_pc_i;
    logic [XLEN-1:0] br_imm_i;
    logic [XLEN-1:0] br_rs1_i;
    logic            br_pred_taken_i;
    logic            beq_i;
    logic            bne_i;
    logic            blt_i;
    logic            bge_i;
    logic            bltu_i;
    logic            bgeu_i;
    logic            redir_valid_o;
    logic            redir_ready_i;
    logic [XLEN-1:0] redir_pc_o;

    modport master (
        output br_valid_i, br_kind_i, br_funct3_i, br_pc_i, br_imm_i, br_rs1_i,
               br_pred_taken_i, beq_i, bne_i, blt_i, bge_i, bltu_i, bgeu_i, redir_ready_i,
        input  br_ready_o, redir_valid_o, redir_pc_o
    );

    modport slave (
        input  br_valid_i, br_kind_i, br_funct3_i, br_pc_i, br_imm_i, br_rs1_i,
               br_pred_taken_i, beq_i, bne_i, blt_i, bge_i, bltu_i, bgeu_i, redir_ready_i,
        output br_ready_o, redir_valid_o, redir_pc_o
    );

endinterface

// File: rtl/branch_cond_sel.sv
// Combinational funct3 mux over the comparator flags; flags unused encodings
// 010/011 as illegal.
module branch_cond_sel
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  br_flags_t  flags,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (funct3)
            F3_BEQ:  taken = flags.beq;
            F3_BNE:  taken = flags.bne;
            F3_BLT:  taken = flags.blt;
            F3_BGE:  taken = flags.bge;
            F3_BLTU: taken = flags.bltu;
            F3_BGEU: taken = flags.bgeu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves one captured branch per EVAL cycle: picks the taken flag, computes the
// real next PC, flushes and redirects fetch on a mispredict, and counts branches.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus,
    output logic                 flush_o,
    output logic                 link_valid_o,
    output logic [XLEN-1:0]      link_data_o,
    output logic                 illegal_o,
    output logic [CNT_W-1:0]     br_count_o,
    output logic [CNT_W-1:0]     mispred_count_o
);

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    br_state_t       state_q, state_d;
    logic            capture;

    logic [1:0]      kind_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q, imm_q, rs1_q;
    logic            pred_q;
    br_flags_t       flags_q;

    logic             ready_q, ready_d;
    logic             redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
    logic             flush_q, flush_d;
    logic             link_valid_q, link_valid_d;
    logic [XLEN-1:0]  link_data_q, link_data_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic            cond_taken, cond_illegal;
    logic            is_cond, is_jal, is_jalr;
    logic            br_illegal, br_taken, br_mispred;
    logic [XLEN-1:0] pc_plus4, jalr_sum, target, actual_pc;

    branch_cond_sel u_cond_sel (
        .funct3  (funct3_q),
        .flags   (flags_q),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    always_comb begin
        is_cond    = (kind_q == KIND_COND);
        is_jal     = (kind_q == KIND_JAL);
        is_jalr    = (kind_q == KIND_JALR);
        br_illegal = !(is_cond || is_jal || is_jalr) || (is_cond && cond_illegal);
        br_taken   = is_cond ? cond_taken : 1'b1;
        pc_plus4   = pc_q + PC_STEP;
        jalr_sum   = rs1_q + imm_q;
        target     = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
        actual_pc  = br_taken ? target : pc_plus4;
        // JALR targets are never predicted, so they always redirect.
        br_mispred = is_jalr || (br_taken != pred_q);
    end

    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        ready_d       = ready_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = 1'b0;
        link_valid_d  = 1'b0;
        link_data_d   = link_data_q;
        illegal_d     = 1'b0;
        br_cnt_d      = br_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bus.br_valid_i && ready_q) begin
                    capture = 1'b1;
                    ready_d = 1'b0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (br_illegal) begin
                    illegal_d = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    br_cnt_d = br_cnt_q + CNT_ONE;
                    if (is_jal || is_jalr) begin
                        link_valid_d = 1'b1;
                        link_data_d  = pc_plus4;
                    end
                    if (br_mispred) begin
                        flush_d       = 1'b1;
                        mis_cnt_d     = mis_cnt_q + CNT_ONE;
                        redir_valid_d = 1'b1;
                        redir_pc_d    = actual_pc;
                        state_d       = ST_REDIRECT;
                    end else begin
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REDIRECT: begin
                if (bus.redir_ready_i) begin
                    redir_valid_d = 1'b0;
                    ready_d       = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                redir_valid_d = 1'b0;
                ready_d       = 1'b1;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            link_valid_q  <= 1'b0;
            link_data_q   <= '0;
            illegal_q     <= 1'b0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            link_valid_q  <= link_valid_d;
            link_data_q   <= link_data_d;
            illegal_q     <= illegal_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= KIND_COND;
            funct3_q <= F3_BEQ;
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            pred_q   <= 1'b0;
            flags_q  <= '0;
        end else if (capture) begin
            kind_q   <= bus.br_kind_i;
            funct3_q <= bus.br_funct3_i;
            pc_q     <= bus.br_pc_i;
            imm_q    <= bus.br_imm_i;
            rs1_q    <= bus.br_rs1_i;
            pred_q   <= bus.br_pred_taken_i;
            flags_q  <= {bus.beq_i, bus.bne_i, bus.blt_i, bus.bge_i, bus.bltu_i, bus.bgeu_i};
        end
    end

    assign bus.br_ready_o    = ready_q;
    assign bus.redir_valid_o = redir_valid_q;
    assign bus.redir_pc_o    = redir_pc_q;
    assign flush_o           = flush_q;
    assign link_valid_o      = link_valid_q;
    assign link_data_o       = link_data_q;
    assign illegal_o         = illegal_q;
    assign br_count_o        = br_cnt_q;
    assign mispred_count_o   = mis_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer of the branch-condition flags produced by the execute-stage comparator (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Selects the flag for the issued branch, computes the actual next PC and compares it against the fetch prediction.
- On a mispredict it flushes the pipeline and issues a PC redirect to fetch over a valid/ready handshake.
- Also produces the JAL/JALR link value and keeps branch and mispredict counters.

Parameters:
- XLEN, 32, datapath/PC width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid_i  in  1  branch offered by execute.
- br_ready_o  out  1  unit can accept a branch.
- br_kind_i  in  2  00 conditional, 01 JAL, 10 JALR, 11 reserved.
- br_funct3_i  in  3  branch condition select.
- br_pc_i  in  XLEN  PC of the branch.
- br_imm_i  in  XLEN  sign-extended offset.
- br_rs1_i  in  XLEN  JALR base register.
- br_pred_taken_i  in  1  fetch predicted taken.
- beq_i, bne_i, blt_i, bge_i, bltu_i, bgeu_i  in  1 each  comparator flags, valid in the br_valid_i cycle.
- redir_valid_o  out  1  redirect request to fetch.
- redir_ready_i  in  1  fetch accepts the redirect.
- redir_pc_o  out  XLEN  redirect target.
- flush_o  out  1  one-cycle pipeline flush pulse.
- link_valid_o  out  1  one-cycle link writeback pulse.
- link_data_o  out  XLEN  pc+4 for JAL/JALR.
- illegal_o  out  1  one-cycle illegal-branch pulse.
- br_count_o  out  CNT_W  resolved-branch counter.
- mispred_count_o  out  CNT_W  mispredict counter.

Behaviour:
- Reset (asynchronous, any state, including mid-redirect): state=IDLE; all outputs and counters 0; redir_valid_o drops with no handshake.
- All outputs are registered. br_ready_o=1 only in IDLE.
- FSM states: IDLE, EVAL, REDIRECT.
- IDLE: when br_valid_i&br_ready_o, capture all br_* inputs and flags, then go to EVAL. br_valid_i while not ready is ignored (not captured).
- EVAL (one cycle), decode:
  - Conditional: taken = flag selected by funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu). Only the selected flag is used; flags are not cross-checked.
  - JAL: taken=1. JALR: taken=1.
- EVAL, targets:
  - Conditional and JAL target = pc+imm.
  - JALR target = (rs1+imm) with bit0 cleared.
  - All sums are modulo 2^XLEN.
  - actual_pc = taken ? target : pc+4.
- EVAL, mispredict:
  - Conditional/JAL: mispredict = taken XOR pred_taken.
  - JALR: always a mispredict.
- Illegal: kind=11, or conditional with funct3 010/011. Result: illegal_o pulse, no flush, no redirect, no link, counters unchanged.
- Latency: branch accepted on edge N.
  - Cycle N+2: flush_o, link_valid_o (JAL/JALR) and illegal_o pulse for exactly one cycle.
  - br_count_o increments (legal only). mispred_count_o increments on a mispredict.
  - On a mispredict: state REDIRECT, redir_valid_o=1, redir_pc_o=actual_pc. Otherwise state IDLE and br_ready_o=1 at N+2.
- REDIRECT: redir_valid_o and redir_pc_o held stable until redir_ready_i=1. Handshake on that edge returns the FSM to IDLE. redir_ready_i already high at N+2 means IDLE at N+3.
- redir_ready_i outside REDIRECT is ignored.
- Counters wrap to 0 on overflow; no saturation.
- Throughput: one branch per 2 cycles when there is no redirect.

Decomposition:
- Shared package branch_pkg holds:
  - funct3 constants F3_BEQ/F3_BNE/F3_BLT/F3_BGE/F3_BLTU/F3_BGEU.
  - br_kind encodings KIND_COND/KIND_JAL/KIND_JALR.
  - FSM state enum.
- One sub-module: branch_cond_sel, a combinational funct3 flag mux with an illegal output.
- Target arithmetic, FSM and counters stay in the top module.

Test Plan:
- BEQ taken, pred 0: pc=0x100, imm=0x20, beq_i=1. Expect at N+2: flush_o=1 for one cycle, redir_valid_o=1, redir_pc_o=0x120, br_count_o=1, mispred_count_o=1.
- BNE not taken, pred 0: bne_i=0, pc=0x200. Expect: no flush, no redirect, br_ready_o=1 at N+2, br_count_o+1, mispred unchanged.
- JALR rs1=0x2003, imm=0x10, pc=0x400. Expect: redir_pc_o=0x2012, link_valid_o pulse, link_data_o=0x404, flush_o pulse.
- Backpressure: redir_ready_i low for 5 cycles during REDIRECT. Expect: redir_valid_o/redir_pc_o stable, br_ready_o=0, a concurrent br_valid_i is not captured, IDLE one edge after ready rises.
- Illegal: funct3=010 conditional. Expect: illegal_o pulse at N+2, flush_o=0, redir_valid_o=0, both counters unchanged.
- Reset in REDIRECT: rst_n low asynchronously. Expect: redir_valid_o=0 and counters=0 immediately, IDLE with br_ready_o=1 after release. With CNT_W=4, 16 legal branches wrap br_count_o to 0.
